// File: rtl/multicycle_control_fsm.sv
// Main controller for the RISC-V multicycle datapath.
// A Moore state machine walks each instruction through fetch, decode,
// address, memory, execute and writeback phases, and drives every
// datapath enable and mux select. lw, sw, R-type, I-type ALU, beq and
// jal are supported; any other opcode ends the instruction in DECODE
// with a one-cycle illegal_op pulse.
//
// Optional feature: define MEM_READY_EN to add the mem_ready input.
// FETCH, MEMREAD and MEMWRITE then hold until mem_ready=1. Without the
// macro the port does not exist and each of those states lasts one cycle.
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef MEM_READY_EN
    input  logic               mem_ready,
`endif
    input  logic [6:0]         Op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    // State encoding is fixed because it is visible on the debug port.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Internal ALU operation class, expanded to ALUControl below.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Expand the ALU operation class into the ALU control code.
    // Only R-type (Op[5]=1) may turn funct3=000 into a subtract, so
    // addi with instruction bit 30 set still adds.
    function automatic logic [2:0] alu_decode(
        input logic [1:0] alu_op,
        input logic [2:0] f3,
        input logic       op5,
        input logic       f7b5
    );
        logic [2:0] ctl;
        ctl = 3'b000;
        case (alu_op)
            ALUOP_ADD: ctl = 3'b000;
            ALUOP_SUB: ctl = 3'b001;
            ALUOP_FUNCT: begin
                case (f3)
                    3'b000: begin
                        if (op5 & f7b5) begin
                            ctl = 3'b001;
                        end else begin
                            ctl = 3'b000;
                        end
                    end
                    3'b010:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               mem_ready_s;
    logic               illegal_s;
    logic               pc_update_s;
    logic               branch_s;
    logic [1:0]         alu_op_s;
    logic               adr_src_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic [1:0]         result_src_s;
    logic [1:0]         alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [1:0]         imm_src_s;
    logic               reg_write_s;
    logic               instr_done_s;

`ifdef MEM_READY_EN
    assign mem_ready_s = mem_ready;
`else
    assign mem_ready_s = 1'b1;
`endif

    // State register; reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and illegal opcode detection in DECODE.
    always_comb begin
        state_d   = S_FETCH;
        illegal_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                // Op[5] separates sw (0100011) from lw (0000011).
                if (Op[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (mem_ready_s) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: state_d = S_ALUWB;
            S_EXECI: state_d = S_ALUWB;
            S_ALUWB: state_d = S_FETCH;
            S_BEQ:   state_d = S_FETCH;
            S_JAL:   state_d = S_ALUWB;
            default: state_d = S_FETCH;
        endcase
    end

    // Per-state Moore outputs; undefined states leave everything low.
    always_comb begin
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = ALUOP_ADD;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed on the ALU and routed straight to the PC.
                ir_write_s   = mem_ready_s;
                pc_update_s  = mem_ready_s;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
            end
            S_DECODE: begin
                // Precompute the branch target OldPC + imm into ALUOut.
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b01;
                instr_done_s = illegal_s;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready_s;
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b00;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src_s = 2'b00;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b00;
                alu_op_s     = ALUOP_SUB;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                // Link value OldPC + 4 goes to ALUOut; the PC takes the
                // target precomputed in DECODE.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        case (Op)
            OP_LW, OP_I: imm_src_s = 2'b00;
            OP_SW:       imm_src_s = 2'b01;
            OP_BEQ:      imm_src_s = 2'b10;
            OP_JAL:      imm_src_s = 2'b11;
            default:     imm_src_s = 2'b00;
        endcase
    end

    assign PCWrite    = pc_update_s | (branch_s & Zero);
    assign AdrSrc     = adr_src_s;
    assign MemWrite   = mem_write_s;
    assign IRWrite    = ir_write_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ImmSrc     = imm_src_s;
    assign ALUControl = alu_decode(alu_op_s, funct3, Op[5], funct7b5);
    assign RegWrite   = reg_write_s;
    assign illegal_op = illegal_s;
    assign instr_done = instr_done_s;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm (default build).
// The driver issues directed then random instructions and pushes the
// expected per-cycle control trace of each one into a queue; a monitor
// process pops one entry per cycle and compares it with the DUT outputs.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       rw;
        logic       ill;
        logic       done;
    } rec_t;

    logic       clk;
    logic       reset;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic       illegal_op, instr_done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int   n_checks;
    int   n_pass;
    bit   mon_en;
    rec_t exp_q[$];

    multicycle_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
        .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic rec_t sample();
        rec_t r;
        r.st = state; r.pcw = PCWrite; r.adr = AdrSrc; r.mw = MemWrite;
        r.irw = IRWrite; r.rs = ResultSrc; r.sa = ALUSrcA; r.sb = ALUSrcB;
        r.imm = ImmSrc; r.alu = ALUControl; r.rw = RegWrite;
        r.ill = illegal_op; r.done = instr_done;
        return r;
    endfunction

    function automatic rec_t blank(input logic [3:0] st, input logic [1:0] imm);
        rec_t r;
        r = '0;
        r.st = st;
        r.imm = imm;
        return r;
    endfunction

    // Reference model: the cycle-by-cycle control trace of one instruction.
    task automatic push_instr(input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic z);
        logic [1:0] imm;
        logic [2:0] fn;
        rec_t r;
        if (op == 7'b0100011)      imm = 2'd1;
        else if (op == 7'b1100011) imm = 2'd2;
        else if (op == 7'b1101111) imm = 2'd3;
        else                       imm = 2'd0;
        case (f3)
            3'd0:    fn = (op[5] && f7) ? 3'd1 : 3'd0;
            3'd2:    fn = 3'd5;
            3'd6:    fn = 3'd3;
            3'd7:    fn = 3'd2;
            default: fn = 3'd0;
        endcase
        // Every instruction: fetch (PC+4 to PC, IR load) then decode.
        r = blank(4'd0, imm); r.irw = 1'b1; r.pcw = 1'b1; r.sb = 2'd2; r.rs = 2'd2;
        exp_q.push_back(r);
        r = blank(4'd1, imm); r.sa = 2'd1; r.sb = 2'd1;
        if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111})) begin
            r.ill = 1'b1; r.done = 1'b1;
            exp_q.push_back(r);
            return;
        end
        exp_q.push_back(r);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            r = blank(4'd2, imm); r.sa = 2'd2; r.sb = 2'd1;
            exp_q.push_back(r);
            if (op == 7'b0000011) begin
                r = blank(4'd3, imm); r.adr = 1'b1;
                exp_q.push_back(r);
                r = blank(4'd4, imm); r.rs = 2'd1; r.rw = 1'b1; r.done = 1'b1;
                exp_q.push_back(r);
            end else begin
                r = blank(4'd5, imm); r.adr = 1'b1; r.mw = 1'b1; r.done = 1'b1;
                exp_q.push_back(r);
            end
            return;
        end
        if (op == 7'b1100011) begin
            r = blank(4'd9, imm); r.sa = 2'd2; r.alu = 3'd1; r.pcw = z; r.done = 1'b1;
            exp_q.push_back(r);
            return;
        end
        if (op == 7'b0110011) begin
            r = blank(4'd6, imm); r.sa = 2'd2; r.alu = fn;
        end else if (op == 7'b0010011) begin
            r = blank(4'd7, imm); r.sa = 2'd2; r.sb = 2'd1; r.alu = fn;
        end else begin
            r = blank(4'd10, imm); r.sa = 2'd1; r.sb = 2'd2; r.pcw = 1'b1;
        end
        exp_q.push_back(r);
        r = blank(4'd8, imm); r.rw = 1'b1; r.done = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z);
        Op = op; funct3 = f3; funct7b5 = f7; Zero = z;
        push_instr(op, f3, f7, z);
    endtask

    // Wait (bounded) for the DUT to signal the last cycle of the instruction.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (instr_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL instr_timeout: instr_done not seen within 10 cycles, Op=%b", Op);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam int ND = 11;
    logic [6:0] d_op [ND] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b0110011, 7'b1100011, 7'b1100011, 7'b1101111,
                              7'b1111111, 7'b0110011, 7'b0010011};
    logic [2:0] d_f3 [ND] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0,
                              3'd0, 3'd2, 3'd7};
    logic       d_f7 [ND] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0};
    logic       d_z  [ND] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0};
    logic [6:0] legal [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1100011, 7'b1101111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; mon_en = 1'b0;
        reset = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;

        // Monitor: one scoreboard entry per active cycle.
        fork
            forever begin
                rec_t got;
                rec_t exp;
                @(negedge clk);
                if (mon_en && !reset) begin
                    got = sample();
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL cycle_unexpected: got %h expected none", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check($sformatf("cycle st%0d", exp.st), 32'(got), 32'(exp));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_regwrite", 32'(RegWrite), 32'd0);
        check("reset_memwrite", 32'(MemWrite), 32'd0);
        check("reset_irwrite", 32'(IRWrite), 32'd1);
        check("reset_pcwrite", 32'(PCWrite), 32'd1);

        for (int i = 0; i < ND; i++) begin
            drive(d_op[i], d_f3[i], d_f7[i], d_z[i]);
            if (i == 0) begin
                reset = 1'b0;
                mon_en = 1'b1;
            end
            wait_done();
        end

        for (int i = 0; i < 150; i++) begin
            logic [6:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel < 6) op = legal[sel];
            else op = 7'($urandom_range(0, 127));
            drive(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            wait_done();
        end

        // Abort an sw in MEMADR with reset: no write may follow.
        drive(7'b0100011, 3'd2, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("abort_state", 32'(state), 32'd0);
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        check("abort_regwrite", 32'(RegWrite), 32'd0);
        check("abort_done", 32'(instr_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held_state", 32'(state), 32'd0);
        check("held_memwrite", 32'(MemWrite), 32'd0);

        // Recovery after reset with a full lw.
        drive(7'b0000011, 3'd2, 1'b0, 1'b0);
        reset = 1'b0;
        mon_en = 1'b1;
        wait_done();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
